// File: rtl/demux1to4_regbank.sv
// -----------------------------------------------------------------------------
// demux1to4_regbank
//
// Write-side counterpart of a 4:1 select path. A WIDTH-bit word is steered by
// the 2-bit select {S1,S0} into one of four holding registers Q0..Q3. These
// registers drive the I0..I3 inputs of the read mux directly. Every write goes
// through a one-entry pending stage before it reaches its Q register.
//
// Handshake: a write is accepted on a rising clk edge where wr_valid and
// wr_ready are both 1. wr_ready is combinational and does not depend on
// wr_valid. While wr_ready is 0 the source keeps wr_valid, din, S1 and S0
// stable, and nothing is captured.
//
// Optional feature: define DEMUX_WRCOUNT_EN to add the per-index saturating
// commit counters wcnt0..wcnt3.
//
// Parameters:
//   WIDTH    data width of din and of each Q register
//   RST_VAL  value loaded into Q0..Q3 on reset and on clr
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   din       write data
//   S0, S1    destination index, {S1,S0}
//   wr_valid  write request
//   wr_ready  pending stage can accept
//   hold      stall; blocks commit of the pending entry
//   clr       synchronous clear of Q0..Q3, the pending entry and the counters
//   Q0..Q3    holding registers for index 0..3
//   wr_done   one-cycle pulse after the edge where an entry commits
//   wr_idx    index just committed; meaningful only while wr_done=1
//   wcnt0..3  (DEMUX_WRCOUNT_EN) saturating count of commits per index
// -----------------------------------------------------------------------------
module demux1to4_regbank #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             S0,
  input  logic             S1,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             hold,
  input  logic             clr,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic             wr_done,
  output logic [1:0]       wr_idx
`ifdef DEMUX_WRCOUNT_EN
  ,
  output logic [7:0]       wcnt0,
  output logic [7:0]       wcnt1,
  output logic [7:0]       wcnt2,
  output logic [7:0]       wcnt3
`endif
);

  // Holding registers
  logic [WIDTH-1:0] q_q [4];
  logic [WIDTH-1:0] q_d [4];

  // Pending stage
  logic             pend_v_q,    pend_v_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;
  logic [1:0]       pend_idx_q,  pend_idx_d;

  // Commit report
  logic             done_q, done_d;
  logic [1:0]       idx_q,  idx_d;

  // Set at the first clk edge after reset release. wr_ready stays low until
  // then, so reset release is seen through the clock and not only through
  // the rst_n level.
  logic             run_q;

  logic             accept;
  logic             commit;

  assign wr_ready = rst_n & run_q & ~clr & (~pend_v_q | ~hold);
  assign accept   = wr_valid & wr_ready;
  // clr overrides commit: a pending entry that meets clr is discarded.
  assign commit   = pend_v_q & ~hold & ~clr;

  always_comb begin
    q_d         = q_q;
    pend_v_d    = pend_v_q;
    pend_data_d = pend_data_q;
    pend_idx_d  = pend_idx_q;
    done_d      = 1'b0;
    idx_d       = 2'b00;

    if (clr) begin
      for (int k = 0; k < 4; k++) begin
        q_d[k] = RST_VAL;
      end
      pend_v_d = 1'b0;
    end else begin
      if (commit) begin
        q_d[pend_idx_q] = pend_data_q;
        done_d          = 1'b1;
        idx_d           = pend_idx_q;
      end
      // A new accept refills the stage in the same edge the old entry
      // drains, which keeps a steady stream at one write per cycle.
      if (accept) begin
        pend_v_d    = 1'b1;
        pend_data_d = din;
        pend_idx_d  = {S1, S0};
      end else if (commit) begin
        pend_v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        q_q[k] <= RST_VAL;
      end
      pend_v_q    <= 1'b0;
      pend_data_q <= '0;
      pend_idx_q  <= 2'b00;
      done_q      <= 1'b0;
      idx_q       <= 2'b00;
      run_q       <= 1'b0;
    end else begin
      q_q         <= q_d;
      pend_v_q    <= pend_v_d;
      pend_data_q <= pend_data_d;
      pend_idx_q  <= pend_idx_d;
      done_q      <= done_d;
      idx_q       <= idx_d;
      run_q       <= 1'b1;
    end
  end

  assign Q0      = q_q[0];
  assign Q1      = q_q[1];
  assign Q2      = q_q[2];
  assign Q3      = q_q[3];
  assign wr_done = done_q;
  assign wr_idx  = idx_q;

`ifdef DEMUX_WRCOUNT_EN
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      for (int k = 0; k < 4; k++) begin
        cnt_d[k] = 8'd0;
      end
    end else if (commit && (cnt_q[pend_idx_q] != 8'hFF)) begin
      cnt_d[pend_idx_q] = cnt_q[pend_idx_q] + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= 8'd0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign wcnt0 = cnt_q[0];
  assign wcnt1 = cnt_q[1];
  assign wcnt2 = cnt_q[2];
  assign wcnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux1to4_regbank.sv
// -----------------------------------------------------------------------------
// tb_demux1to4_regbank
//
// Self-checking bench for demux1to4_regbank (WIDTH=32, RST_VAL=0).
// Directed vectors carry hand-computed expectations; randomized traffic is
// compared against a queue-based reference model of the write path.
// -----------------------------------------------------------------------------
module tb_demux1to4_regbank;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [W-1:0]  din;
  logic          S0, S1;
  logic          wr_valid;
  logic          wr_ready;
  logic          hold;
  logic          clr;
  logic [W-1:0]  Q0, Q1, Q2, Q3;
  logic          wr_done;
  logic [1:0]    wr_idx;
`ifdef DEMUX_WRCOUNT_EN
  logic [7:0]    wcnt0, wcnt1, wcnt2, wcnt3;
`endif

  demux1to4_regbank #(.WIDTH(W), .RST_VAL('0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .S0       (S0),
    .S1       (S1),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .hold     (hold),
    .clr      (clr),
    .Q0       (Q0),
    .Q1       (Q1),
    .Q2       (Q2),
    .Q3       (Q3),
    .wr_done  (wr_done),
    .wr_idx   (wr_idx)
`ifdef DEMUX_WRCOUNT_EN
    ,
    .wcnt0    (wcnt0),
    .wcnt1    (wcnt1),
    .wcnt2    (wcnt2),
    .wcnt3    (wcnt3)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]   idx;
    logic [W-1:0] data;
  } ent_t;

  logic [W-1:0] m_reg [4];
  ent_t         m_pend [$];
  logic         m_done;
  logic [1:0]   m_idx;
  int           m_cnt [4];

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_reg[k] = '0;
      m_cnt[k] = 0;
    end
    m_pend.delete();
    m_done = 1'b0;
    m_idx  = 2'b00;
  endtask

  function automatic logic model_ready(input logic h, input logic c);
    return !c && ((m_pend.size() == 0) || !h);
  endfunction

  task automatic model_edge(input logic [W-1:0] d, input logic [1:0] s,
                            input logic v, input logic h, input logic c);
    logic r;
    ent_t e;
    r = model_ready(h, c);
    m_done = 1'b0;
    m_idx  = 2'b00;
    if (c) begin
      for (int k = 0; k < 4; k++) begin
        m_reg[k] = '0;
        m_cnt[k] = 0;
      end
      m_pend.delete();
    end else begin
      if ((m_pend.size() > 0) && !h) begin
        e = m_pend.pop_front();
        m_reg[e.idx] = e.data;
        m_done = 1'b1;
        m_idx  = e.idx;
        if (m_cnt[e.idx] < 255) m_cnt[e.idx]++;
      end
      if (v && r) begin
        e.idx  = s;
        e.data = d;
        m_pend.push_back(e);
      end
    end
  endtask

  // ---------------- driver ----------------
  logic got_rdy;
  logic exp_rdy_m;

  // One clock cycle: drive on the falling edge, sample wr_ready before the
  // rising edge, update the model at the rising edge, outputs are then
  // sampled 1 time unit later by the caller.
  task automatic cycle(input logic [W-1:0] d, input logic [1:0] s,
                       input logic v, input logic h, input logic c);
    @(negedge clk);
    din      = d;
    S1       = s[1];
    S0       = s[0];
    wr_valid = v;
    hold     = h;
    clr      = c;
    #1;
    got_rdy   = wr_ready;
    exp_rdy_m = model_ready(h, c);
    @(posedge clk);
    model_edge(d, s, v, h, c);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " wr_ready"}, W'(got_rdy), W'(exp_rdy_m));
    chk({tag, " wr_done"},  W'(wr_done), W'(m_done));
    if (m_done) chk({tag, " wr_idx"}, W'(wr_idx), W'(m_idx));
    chk({tag, " Q0"}, Q0, m_reg[0]);
    chk({tag, " Q1"}, Q1, m_reg[1]);
    chk({tag, " Q2"}, Q2, m_reg[2]);
    chk({tag, " Q3"}, Q3, m_reg[3]);
`ifdef DEMUX_WRCOUNT_EN
    chk({tag, " wcnt0"}, W'(wcnt0), W'(m_cnt[0]));
    chk({tag, " wcnt1"}, W'(wcnt1), W'(m_cnt[1]));
    chk({tag, " wcnt2"}, W'(wcnt2), W'(m_cnt[2]));
    chk({tag, " wcnt3"}, W'(wcnt3), W'(m_cnt[3]));
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [W-1:0] din;
    logic [1:0]   sel;
    logic         v, h, c;
    logic         exp_rdy;
    logic         exp_done;
    logic [1:0]   exp_idx;
    logic [W-1:0] e0, e1, e2, e3;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic [W-1:0] d, input logic [1:0] s,
                              input logic v, input logic h, input logic c,
                              input logic rdy, input logic dn, input logic [1:0] ix,
                              input logic [W-1:0] e0, input logic [W-1:0] e1,
                              input logic [W-1:0] e2, input logic [W-1:0] e3);
    vec_t t;
    t.din = d; t.sel = s; t.v = v; t.h = h; t.c = c;
    t.exp_rdy = rdy; t.exp_done = dn; t.exp_idx = ix;
    t.e0 = e0; t.e1 = e1; t.e2 = e2; t.e3 = e3;
    return t;
  endfunction

  initial begin
    string tag;
    logic [W-1:0] db;
    db = 32'hDEAD_BEEF;

    // single write to index 2
    vecs.push_back(mk(db,    2, 1, 0, 0, 1, 0, 0, 0, 0, 0,  0));
    vecs.push_back(mk(0,     0, 0, 0, 0, 1, 1, 2, 0, 0, db, 0));
    vecs.push_back(mk(0,     0, 0, 0, 0, 1, 0, 0, 0, 0, db, 0));
    // streaming, one write per cycle
    vecs.push_back(mk('h11,  0, 1, 0, 0, 1, 0, 0, 0,    0,    db,   0));
    vecs.push_back(mk('h22,  1, 1, 0, 0, 1, 1, 0, 'h11, 0,    db,   0));
    vecs.push_back(mk('h33,  2, 1, 0, 0, 1, 1, 1, 'h11, 'h22, db,   0));
    vecs.push_back(mk('h44,  3, 1, 0, 0, 1, 1, 2, 'h11, 'h22, 'h33, 0));
    vecs.push_back(mk(0,     0, 0, 0, 0, 1, 1, 3, 'h11, 'h22, 'h33, 'h44));
    // hold with a full pending stage
    vecs.push_back(mk('hAA,  1, 1, 0, 0, 1, 0, 0, 'h11, 'h22, 'h33, 'h44));
    vecs.push_back(mk('hBB,  1, 1, 1, 0, 0, 0, 0, 'h11, 'h22, 'h33, 'h44));
    vecs.push_back(mk('hBB,  1, 1, 1, 0, 0, 0, 0, 'h11, 'h22, 'h33, 'h44));
    vecs.push_back(mk('hBB,  1, 1, 1, 0, 0, 0, 0, 'h11, 'h22, 'h33, 'h44));
    vecs.push_back(mk('hBB,  1, 1, 0, 0, 1, 1, 1, 'h11, 'hAA, 'h33, 'h44));
    vecs.push_back(mk(0,     0, 0, 0, 0, 1, 1, 1, 'h11, 'hBB, 'h33, 'h44));
    // clear racing a commit
    vecs.push_back(mk('h55,  3, 1, 0, 0, 1, 0, 0, 'h11, 'hBB, 'h33, 'h44));
    vecs.push_back(mk(0,     0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk('h77,  0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,     0, 0, 0, 0, 1, 1, 0, 'h77, 0, 0, 0));
    // hold with an empty stage: one accept, then wr_ready drops
    vecs.push_back(mk('h12,  2, 1, 1, 0, 1, 0, 0, 'h77, 0, 0,    0));
    vecs.push_back(mk('h34,  2, 1, 1, 0, 0, 0, 0, 'h77, 0, 0,    0));
    vecs.push_back(mk(0,     0, 0, 0, 0, 1, 1, 2, 'h77, 0, 'h12, 0));
    vecs.push_back(mk(0,     0, 0, 0, 0, 1, 0, 0, 'h77, 0, 'h12, 0));

    // ---- reset with aggressive inputs ----
    rst_n = 1'b0; din = '1; S0 = 1'b1; S1 = 1'b1;
    wr_valid = 1'b1; hold = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst Q0", Q0, '0);
    chk("rst Q1", Q1, '0);
    chk("rst Q2", Q2, '0);
    chk("rst Q3", Q3, '0);
    chk("rst wr_ready", W'(wr_ready), '0);
    chk("rst wr_done",  W'(wr_done),  '0);
    chk("rst wr_idx",   W'(wr_idx),   '0);
    @(negedge clk);
    rst_n = 1'b1; wr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post-rst wr_ready", W'(wr_ready), W'(1'b1));
    model_reset();

    // ---- table-driven directed vectors ----
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].din, vecs[i].sel, vecs[i].v, vecs[i].h, vecs[i].c);
      tag = $sformatf("vec%0d", i);
      chk({tag, " wr_ready"}, W'(got_rdy), W'(vecs[i].exp_rdy));
      chk({tag, " wr_done"},  W'(wr_done), W'(vecs[i].exp_done));
      if (vecs[i].exp_done) chk({tag, " wr_idx"}, W'(wr_idx), W'(vecs[i].exp_idx));
      chk({tag, " Q0"}, Q0, vecs[i].e0);
      chk({tag, " Q1"}, Q1, vecs[i].e1);
      chk({tag, " Q2"}, Q2, vecs[i].e2);
      chk({tag, " Q3"}, Q3, vecs[i].e3);
    end

    // ---- asynchronous reset while an entry is pending ----
    cycle(32'hCAFE_0001, 2'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst wr_ready", W'(wr_ready), '0);
    chk("arst wr_done",  W'(wr_done),  '0);
    chk("arst Q0", Q0, '0);
    chk("arst Q1", Q1, '0);
    chk("arst Q2", Q2, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("arst-drop wr_done", W'(wr_done), '0);
    chk("arst-drop Q1", Q1, '0);
    model_reset();

    // ---- randomized traffic vs reference model ----
    for (int i = 0; i < 400; i++) begin
      cycle($urandom, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
      check_model($sformatf("rnd%0d", i));
    end

`ifdef DEMUX_WRCOUNT_EN
    // ---- counter saturation and clear ----
    for (int i = 0; i < 300; i++) begin
      cycle(W'(i), 2'd0, 1'b1, 1'b0, 1'b0);
      check_model($sformatf("sat%0d", i));
    end
    cycle('0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("sat wcnt0", W'(wcnt0), W'(255));
    cycle('0, 2'd0, 1'b0, 1'b0, 1'b1);
    check_model("cnt-clr");
    chk("clr wcnt0", W'(wcnt0), '0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
